// File: rtl/logo_bounce_pkg.sv
// rtl/logo_bounce_pkg.sv - shared types and constants for the logo bounce controller
package logo_bounce_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        UPDATE_X = 2'd2,
        UPDATE_Y = 2'd3
    } state_e;

    localparam logic       DIR_POS = 1'b0;
    localparam logic       DIR_NEG = 1'b1;
    localparam logic [9:0] IMG_OOR = 10'h3FF;

endpackage

// File: rtl/logo_bounce_axis_step.sv
// rtl/logo_bounce_axis_step.sv - combinational single-axis bounce step, shared by X and Y
module logo_axis_step
    import logo_bounce_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic [9:0] pos_i,
    input  logic       dir_i,
    input  logic [9:0] limit_i,
    output logic [9:0] next_pos_o,
    output logic       next_dir_o,
    output logic       hit_o
);

    logic [10:0] pos_ext;
    logic [10:0] step_ext;
    logic [10:0] sum_ext;

    // 11-bit arithmetic so pos+STEP near the top of the range cannot wrap
    always_comb begin
        pos_ext    = {1'b0, pos_i};
        step_ext   = 11'(STEP);
        sum_ext    = pos_ext + step_ext;
        next_pos_o = pos_i;
        next_dir_o = dir_i;
        hit_o      = 1'b0;
        if (dir_i == DIR_POS) begin
            if (sum_ext >= {1'b0, limit_i}) begin
                next_pos_o = limit_i;
                next_dir_o = DIR_NEG;
                hit_o      = 1'b1;
            end else begin
                next_pos_o = sum_ext[9:0];
            end
        end else begin
            if (pos_ext <= step_ext) begin
                next_pos_o = 10'd0;
                next_dir_o = DIR_POS;
                hit_o      = 1'b1;
            end else begin
                next_pos_o = pos_i - step_ext[9:0];
            end
        end
    end

endmodule

// File: rtl/logo_bounce.sv
// rtl/logo_bounce.sv - logo position bounce FSM and raster-to-image translation
// Optional edge-hit counter enabled by defining LOGO_BOUNCE_HITS_EN.
module logo_bounce
    import logo_bounce_pkg::*;
#(
    parameter int WIDTH    = 80,
    parameter int HEIGHT   = 96,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int STEP     = 1,
    parameter int INIT_X   = 0,
    parameter int INIT_Y   = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       enable,
    input  logic       frame_tick,
    input  logic [9:0] x_px,
    input  logic [9:0] y_px,
    output logic [9:0] x_img,
    output logic [9:0] y_img,
    output logic       in_logo,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       busy,
    output logic [7:0] hits
);

    localparam logic [9:0] LIMIT_X = 10'(SCREEN_W - WIDTH);
    localparam logic [9:0] LIMIT_Y = 10'(SCREEN_H - HEIGHT);

    state_e     state_q, state_d;
    logic [9:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [9:0] x_img_q, y_img_q;
    logic       hit_q, in_logo_q;

    logic       sel_y;
    logic [9:0] step_pos, step_limit, step_next_pos;
    logic       step_dir, step_next_dir, step_hit;
    logic       win_hit;

    // One step unit, time-multiplexed: X in UPDATE_X, Y in UPDATE_Y
    assign sel_y      = (state_q == UPDATE_Y);
    assign step_pos   = sel_y ? pos_y_q : pos_x_q;
    assign step_dir   = sel_y ? dir_y_q : dir_x_q;
    assign step_limit = sel_y ? LIMIT_Y : LIMIT_X;

    logo_axis_step #(.STEP(STEP)) u_step (
        .pos_i      (step_pos),
        .dir_i      (step_dir),
        .limit_i    (step_limit),
        .next_pos_o (step_next_pos),
        .next_dir_o (step_next_dir),
        .hit_o      (step_hit)
    );

    always_comb begin
        state_d = state_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        unique case (state_q)
            IDLE: if (enable) state_d = WAIT;
            WAIT: begin
                if (!enable)         state_d = IDLE;
                else if (frame_tick) state_d = UPDATE_X;
            end
            UPDATE_X: begin
                state_d = UPDATE_Y;
                pos_x_d = step_next_pos;
                dir_x_d = step_next_dir;
            end
            UPDATE_Y: begin
                state_d = WAIT;
                pos_y_d = step_next_pos;
                dir_y_d = step_next_dir;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            pos_x_q <= 10'(INIT_X);
            pos_y_q <= 10'(INIT_Y);
            dir_x_q <= DIR_POS;
            dir_y_q <= DIR_POS;
        end else begin
            state_q <= state_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
        end
    end

    assign win_hit = ({1'b0, x_px} >= {1'b0, pos_x_q})
                  && ({1'b0, x_px} <  ({1'b0, pos_x_q} + 11'(WIDTH)))
                  && ({1'b0, y_px} >= {1'b0, pos_y_q})
                  && ({1'b0, y_px} <  ({1'b0, pos_y_q} + 11'(HEIGHT)));

    // Out-of-window pixels address IMG_OOR so the ROM returns background;
    // in_logo trails by one more stage to line up with the ROM output register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_img_q   <= IMG_OOR;
            y_img_q   <= IMG_OOR;
            hit_q     <= 1'b0;
            in_logo_q <= 1'b0;
        end else begin
            x_img_q   <= win_hit ? (x_px - pos_x_q) : IMG_OOR;
            y_img_q   <= win_hit ? (y_px - pos_y_q) : IMG_OOR;
            hit_q     <= win_hit;
            in_logo_q <= hit_q;
        end
    end

`ifdef LOGO_BOUNCE_HITS_EN
    logic [7:0] hits_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hits_q <= 8'd0;
        end else if (busy && step_hit) begin
            hits_q <= hits_q + 8'd1;
        end
    end

    assign hits = hits_q;
`else
    logic unused_step_hit;

    assign unused_step_hit = step_hit;
    assign hits            = 8'd0;
`endif

    assign busy    = (state_q == UPDATE_X) || (state_q == UPDATE_Y);
    assign x_img   = x_img_q;
    assign y_img   = y_img_q;
    assign in_logo = in_logo_q;
    assign pos_x   = pos_x_q;
    assign pos_y   = pos_y_q;

endmodule

// File: tb/tb_logo_bounce.sv
// tb/tb_logo_bounce.sv - directed self-checking bench for logo_bounce
module tb_logo_bounce;

`ifdef LOGO_BOUNCE_HITS_EN
    localparam bit HITS_EN = 1'b1;
`else
    localparam bit HITS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       enable = 1'b0;
    logic       frame_tick = 1'b0;
    logic       frame_tick2 = 1'b0;
    logic [9:0] x_px = 10'd0;
    logic [9:0] y_px = 10'd0;

    logic [9:0] x_img, y_img, pos_x, pos_y;
    logic       in_logo, busy;
    logic [7:0] hits;
    logic [9:0] x_img2, y_img2, pos_x2, pos_y2;
    logic       in_logo2, busy2;
    logic [7:0] hits2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Main DUT: 334 frames from (226,50) reach the bottom-right corner on both axes
    logo_bounce #(.INIT_X(226), .INIT_Y(50)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .frame_tick(frame_tick),
        .x_px(x_px), .y_px(y_px), .x_img(x_img), .y_img(y_img),
        .in_logo(in_logo), .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .hits(hits)
    );

    // Limit 1 on both axes: every axis update is a hit
    logo_bounce #(.SCREEN_W(81), .SCREEN_H(97)) dut2 (
        .clk(clk), .rstn(rstn), .enable(enable), .frame_tick(frame_tick2),
        .x_px(x_px), .y_px(y_px), .x_img(x_img2), .y_img(y_img2),
        .in_logo(in_logo2), .pos_x(pos_x2), .pos_y(pos_y2), .busy(busy2), .hits(hits2)
    );

    task automatic tick_main();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic tick_dut2();
        @(negedge clk) frame_tick2 = 1'b1;
        @(negedge clk) frame_tick2 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (pos_x !== 10'd226) begin failures++; $display("FAIL reset_pos_x got=%0d exp=226", pos_x); end
        checks++; if (pos_y !== 10'd50) begin failures++; $display("FAIL reset_pos_y got=%0d exp=50", pos_y); end
        checks++; if (x_img !== 10'h3FF || y_img !== 10'h3FF) begin failures++; $display("FAIL reset_img got=%h/%h exp=3ff/3ff", x_img, y_img); end
        checks++; if (in_logo !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_flags in_logo=%b busy=%b exp=0/0", in_logo, busy); end
        checks++; if (hits !== 8'd0) begin failures++; $display("FAIL reset_hits got=%0d exp=0", hits); end
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || pos_x !== 10'd226) begin failures++; $display("FAIL idle_hold busy=%b pos_x=%0d exp=0/226", busy, pos_x); end
    endtask

    task automatic test_translation();
        logic [9:0] vx [6] = '{10'd256, 10'd306, 10'd305, 10'd225, 10'd256, 10'd226};
        logic [9:0] vy [6] = '{10'd60,  10'd60,  10'd145, 10'd100, 10'd146, 10'd50};
        logic [9:0] ex [6] = '{10'd30,  10'h3FF, 10'd79,  10'h3FF, 10'h3FF, 10'd0};
        logic [9:0] ey [6] = '{10'd10,  10'h3FF, 10'd95,  10'h3FF, 10'h3FF, 10'd0};
        logic       ei [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       prev_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            x_px = vx[i];
            y_px = vy[i];
            @(negedge clk);
            checks++; if (x_img !== ex[i] || y_img !== ey[i]) begin failures++; $display("FAIL translate_%0d got=%h/%h exp=%h/%h", i, x_img, y_img, ex[i], ey[i]); end
            checks++; if (in_logo !== prev_in) begin failures++; $display("FAIL in_logo_%0d got=%b exp=%b", i, in_logo, prev_in); end
            prev_in = ei[i];
        end
        x_px = 10'd0;
        y_px = 10'd0;
        @(negedge clk);
        checks++; if (in_logo !== prev_in) begin failures++; $display("FAIL in_logo_last got=%b exp=%b", in_logo, prev_in); end
    endtask

    task automatic test_hits_wrap();
        enable = 1'b1;
        repeat (2) @(negedge clk);
        for (int f = 0; f < 127; f++) tick_dut2();
        checks++; if (hits2 !== (HITS_EN ? 8'd254 : 8'd0)) begin failures++; $display("FAIL wrap_254 got=%0d exp=%0d", hits2, HITS_EN ? 254 : 0); end
        checks++; if (pos_x2 !== 10'd1 || pos_y2 !== 10'd1) begin failures++; $display("FAIL wrap_pos got=%0d,%0d exp=1,1", pos_x2, pos_y2); end
        @(negedge clk) frame_tick2 = 1'b1;
        @(negedge clk) frame_tick2 = 1'b0;
        @(negedge clk);
        checks++; if (hits2 !== (HITS_EN ? 8'd255 : 8'd0) || pos_x2 !== 10'd0) begin failures++; $display("FAIL wrap_255 hits=%0d pos_x=%0d exp=%0d/0", hits2, pos_x2, HITS_EN ? 255 : 0); end
        @(negedge clk);
        checks++; if (hits2 !== 8'd0 || pos_y2 !== 10'd0) begin failures++; $display("FAIL wrap_0 hits=%0d pos_y=%0d exp=0/0", hits2, pos_y2); end
        checks++; if (pos_x !== 10'd226 || busy !== 1'b0) begin failures++; $display("FAIL main_untouched pos_x=%0d busy=%b exp=226/0", pos_x, busy); end
    endtask

    task automatic test_bounce();
        @(negedge clk) frame_tick = 1'b1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_pre got=%b exp=0", busy); end
        @(negedge clk) frame_tick = 1'b0;
        checks++; if (busy !== 1'b1 || pos_x !== 10'd226) begin failures++; $display("FAIL upd_x busy=%b pos_x=%0d exp=1/226", busy, pos_x); end
        @(negedge clk);
        checks++; if (busy !== 1'b1 || pos_x !== 10'd227 || pos_y !== 10'd50) begin failures++; $display("FAIL upd_y busy=%b pos=%0d,%0d exp=1/227,50", busy, pos_x, pos_y); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || pos_y !== 10'd51) begin failures++; $display("FAIL upd_done busy=%b pos_y=%0d exp=0/51", busy, pos_y); end
        for (int f = 0; f < 332; f++) tick_main();
        checks++; if (pos_x !== 10'd559 || pos_y !== 10'd383) begin failures++; $display("FAIL pre_corner got=%0d,%0d exp=559,383", pos_x, pos_y); end
        tick_main();
        checks++; if (pos_x !== 10'd560 || pos_y !== 10'd384) begin failures++; $display("FAIL corner got=%0d,%0d exp=560,384", pos_x, pos_y); end
        checks++; if (hits !== (HITS_EN ? 8'd2 : 8'd0)) begin failures++; $display("FAIL corner_hits got=%0d exp=%0d", hits, HITS_EN ? 2 : 0); end
        tick_main();
        checks++; if (pos_x !== 10'd559 || pos_y !== 10'd383) begin failures++; $display("FAIL reversed got=%0d,%0d exp=559,383", pos_x, pos_y); end
        for (int f = 0; f < 383; f++) tick_main();
        checks++; if (pos_x !== 10'd176 || pos_y !== 10'd0) begin failures++; $display("FAIL low_edge got=%0d,%0d exp=176,0", pos_x, pos_y); end
        checks++; if (hits !== (HITS_EN ? 8'd3 : 8'd0)) begin failures++; $display("FAIL low_hits got=%0d exp=%0d", hits, HITS_EN ? 3 : 0); end
        tick_main();
        checks++; if (pos_x !== 10'd175 || pos_y !== 10'd1) begin failures++; $display("FAIL after_low got=%0d,%0d exp=175,1", pos_x, pos_y); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk);
        @(negedge clk) frame_tick = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (pos_x !== 10'd174 || pos_y !== 10'd2 || busy !== 1'b0) begin failures++; $display("FAIL double_tick got=%0d,%0d busy=%b exp=174,2/0", pos_x, pos_y, busy); end
    endtask

    task automatic test_enable();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) begin frame_tick = 1'b0; enable = 1'b0; end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_disable_busy got=%b exp=1", busy); end
        repeat (4) @(negedge clk);
        checks++; if (pos_x !== 10'd173 || pos_y !== 10'd3) begin failures++; $display("FAIL mid_disable_pos got=%0d,%0d exp=173,3", pos_x, pos_y); end
        for (int f = 0; f < 3; f++) tick_main();
        checks++; if (pos_x !== 10'd173 || pos_y !== 10'd3 || busy !== 1'b0) begin failures++; $display("FAIL frozen got=%0d,%0d busy=%b exp=173,3/0", pos_x, pos_y, busy); end
        x_px = 10'd178;
        y_px = 10'd10;
        @(negedge clk);
        checks++; if (x_img !== 10'd5 || y_img !== 10'd7) begin failures++; $display("FAIL frozen_translate got=%0d,%0d exp=5,7", x_img, y_img); end
    endtask

    task automatic test_reset_mid_update();
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pre_reset_busy got=%b exp=1", busy); end
        rstn = 1'b0;
        #1;
        checks++; if (pos_x !== 10'd226 || pos_y !== 10'd50 || busy !== 1'b0) begin failures++; $display("FAIL async_reset got=%0d,%0d busy=%b exp=226,50/0", pos_x, pos_y, busy); end
        checks++; if (x_img !== 10'h3FF || in_logo !== 1'b0 || hits !== 8'd0) begin failures++; $display("FAIL async_reset_out x_img=%h in_logo=%b hits=%0d exp=3ff/0/0", x_img, in_logo, hits); end
    endtask

    initial begin
        test_reset();
        test_translation();
        test_hits_wrap();
        test_bounce();
        test_back_to_back();
        test_enable();
        test_reset_mid_update();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
